rv_rf_wport_arb: RTL



---
 rtl/rv_rf_wport_arb_pkg.sv | 28 ++
 rtl/rv_sync_fifo.sv | 52 +++++
 rtl/rv_rf_wport_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/rv_rf_wport_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter: data width,
// buffered MCU result layout and stall state encoding.
`ifndef XLEN
`define XLEN 32
`endif

package rv_rf_wport_arb_pkg;

   localparam int XLEN = `XLEN;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FORCE  = 1'b1
   } stall_st_e;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] wd;
   } mc_res_t;

   localparam int RES_W = $bits(mc_res_t);

   // One-hot register bit; x0 never maps to a bit so it can never be pending.
   function automatic logic [31:0] reg_bit(input logic [4:0] r);
      return (r == 5'd0) ? 32'd0 : (32'd1 << r);
   endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module rv_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rv_rf_wport_arb.sv
// Register-file write-port arbiter: WB always owns the port, MCU results
// drain from a small buffer into idle slots, with a busy scoreboard and
// a starvation-driven pipeline stall.
module rv_rf_wport_arb
   import rv_rf_wport_arb_pkg::*;
#(
   parameter int BUF_DEPTH  = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_wb_rf_we,
   input  logic [4:0]      i_wb_rf_wa,
   input  logic [XLEN-1:0] i_wb_rf_wd,
   input  logic            i_mc_issue,
   input  logic [4:0]      i_mc_issue_rd,
   input  logic            i_mc_valid,
   input  logic [4:0]      i_mc_rd,
   input  logic [XLEN-1:0] i_mc_wd,
   output logic            o_mc_ready,
   output logic            o_rf_we,
   output logic [4:0]      o_rf_wa,
   output logic [XLEN-1:0] o_rf_wd,
   output logic            o_mc_commit,
   output logic [31:0]     o_busy_mask,
   output logic            o_pipe_stall
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic      wb_free;
   logic      buf_full;
   logic      buf_empty;
   logic      push;
   logic      pop;
   mc_res_t   push_res;
   mc_res_t   head;
   stall_st_e state;
   logic [7:0]  starve_cnt;
   logic [31:0] busy;

   // A WB write to x0 is architecturally a no-op, so that slot is free too.
   assign wb_free    = !i_wb_rf_we || (i_wb_rf_wa == 5'd0);
   assign o_mc_ready = !buf_full && !i_rst;
   assign pop        = wb_free && !buf_empty;
   assign push       = i_mc_valid && o_mc_ready && (i_mc_rd != 5'd0);
   assign push_res   = '{rd: i_mc_rd, wd: i_mc_wd};

   rv_sync_fifo #(
      .WIDTH (RES_W),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push),
      .pop   (pop),
      .din   (push_res),
      .full  (buf_full),
      .empty (buf_empty),
      .head  (head)
   );

   always_comb begin
      o_rf_we     = i_wb_rf_we;
      o_rf_wa     = i_wb_rf_wa;
      o_rf_wd     = i_wb_rf_wd;
      o_mc_commit = 1'b0;
      if (pop) begin
         o_rf_we     = 1'b1;
         o_rf_wa     = head.rd;
         o_rf_wd     = head.wd;
         o_mc_commit = 1'b1;
      end
   end

   // Set is OR-ed in after the clear so a same-cycle re-issue keeps the bit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~(pop ? reg_bit(head.rd) : 32'd0))
               | (i_mc_issue ? reg_bit(i_mc_issue_rd) : 32'd0);
      end
   end

   assign o_busy_mask = busy;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         starve_cnt   <= '0;
         state        <= ST_NORMAL;
         o_pipe_stall <= 1'b0;
      end else begin
         if (buf_empty || pop)
            starve_cnt <= '0;
         else if (starve_cnt != 8'hFF)
            starve_cnt <= starve_cnt + 8'd1;

         // A commit in the threshold cycle already relieves the starvation.
         case (state)
            ST_NORMAL: if (starve_cnt == STARVE_LIM && !pop) begin
               state        <= ST_FORCE;
               o_pipe_stall <= 1'b1;
            end
            ST_FORCE: if (pop) begin
               state        <= ST_NORMAL;
               o_pipe_stall <= 1'b0;
            end
            default: begin
               state        <= ST_NORMAL;
               o_pipe_stall <= 1'b0;
            end
         endcase
      end
   end

endmodule
